dd_capture_fifo: RTL
====================

# dd_capture_fifo

Downstream capture stage for the 8-bit `dd` result stream produced by the `bb`/`cc` combine stage. It buffers up to 16 results in a single-writer storage array and presents them to a consumer over a valid/ready handshake. Overflow is flagged rather than stalling the producer, because the producer has no backpressure input.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two.
- `AW`, 4: pointer width; equals log2(`DEPTH`).

Ports:
- `clk`, input, 1: single clock; all state updates on the posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: a `dd` result is present this cycle.
- `in_data`, input, [0:7]: producer `dd` value; bit 0 is the MSB, matching the producer.
- `out_valid`, output, 1: the head entry is valid.
- `out_ready`, input, 1: the consumer accepts the head entry.
- `out_data`, output, [0:7]: head entry.
- `count`, output, [AW:0]: occupancy, 0..`DEPTH`.
- `full`, output, 1: `count == DEPTH`.
- `empty`, output, 1: `count == 0`.
- `overflow`, output, 1: sticky flag; set when a write is dropped.
- `drop_cnt`, output, [7:0]: dropped-write counter; present only with `DD_CAPTURE_DROPCNT_EN`.

## Operation
- push = `in_valid && (!full || pop)`.
- pop = `out_valid && out_ready`.
- Push writes `in_data` at `wr_ptr`, then increments `wr_ptr`. Pop increments `rd_ptr`.
- Pointers are `AW` bits wide and wrap modulo `DEPTH`. `count` is tracked separately: +1 on push only, -1 on pop only, unchanged on both.
- `out_valid = !empty`. `out_data = mem[rd_ptr]`, read combinationally from storage.
- When full, a push and a pop in the same cycle are both accepted. The pop frees the slot in that cycle. `count` stays at `DEPTH`.
- When empty, `in_valid` is accepted. There is no bypass; `out_valid` is 0 in that cycle.
- Drop = `in_valid && full && !pop`. The data is discarded, the pointers are unchanged, and `overflow` is set to 1 on the next edge.
- `overflow` clears only on `rst`.
- The storage array has exactly one writing always-block. No other process may assign to it.
- On reset: `wr_ptr = rd_ptr = 0`, `count = 0`, `empty = 1`, `full = 0`, `out_valid = 0`, `overflow = 0`, `drop_cnt = 0`.
- `out_data` after reset is don't-care until the first push. Storage contents are not cleared.
- If `rst` is asserted mid-stream, it wins over a push or pop in the same cycle. All buffered entries are discarded.

## Timing
- Write-to-read latency is 1 cycle. Data pushed at edge N gives `out_valid = 1` and that data on `out_data` after edge N.
- Sustained throughput is 1 push and 1 pop per cycle.
- `full`, `empty` and `count` are derived from registered state. They have no combinational path from `in_valid` or `out_ready`.
- `out_valid` never depends combinationally on `out_ready`.
- `out_data` must hold stable while `out_valid && !out_ready`.

## Configuration
- `DD_CAPTURE_DROPCNT_EN` defined:
  - The `drop_cnt` port and an 8-bit counter exist.
  - The counter increments once per dropped write and saturates at 255.
  - It resets to 0.
- `DD_CAPTURE_DROPCNT_EN` undefined:
  - The port and the counter are absent.
  - `overflow` remains as the only drop indication.

## Structure
- Shared package `dd_pkg` holds:
  - the `DD_W = 8` constant;
  - the `dd_t` typedef (`logic [0:DD_W-1]`);
  - the default `DEPTH`/`AW` constants.
- Sub-module `dd_capture_mem` is a `DEPTH` x `dd_t` array with one synchronous write port and one asynchronous read port. It is the single driver of the storage.
- `dd_capture_fifo` holds the pointers, the count, the flags and the optional counter.

## Test plan
- Reset, then push 0xA5 with `out_ready = 0` -> the next cycle shows `out_valid = 1`, `out_data = 0xA5`, `count = 1`.
- Push 16 values 0x00..0x0F with no pops -> `full = 1`, `count = 16`, `overflow = 0`. Popping all 16 returns 0x00..0x0F in order, then `empty = 1`.
- At full, push 0xFF with `out_ready = 0` -> the write is dropped and `overflow = 1`. With the macro, `drop_cnt = 1`. After draining, 0xFF is never output.
- At full, push 0x3C with `out_ready = 1` in the same cycle -> the head pops, `count` stays 16, `overflow = 0`, and 0x3C appears last after the drain.
- Run 40 continuous push+pop cycles of an incrementing value -> the pointers wrap twice, the output matches the input sequence with 1-cycle lag, and `count` stays at 1.
- With 9 entries buffered, assert `rst` together with push and pop -> the next cycle shows `count = 0`, `empty = 1`, `overflow = 0`, `drop_cnt = 0`, and no stale data is output.

Source files
------------

// File: rtl/dd_pkg.sv
// Shared types and default sizing for the dd result stream.
package dd_pkg;
   localparam int unsigned DD_W      = 8;
   localparam int unsigned DEPTH_DEF = 16;
   localparam int unsigned AW_DEF    = 4;

   // Bit 0 is the MSB, matching the producer's declaration.
   typedef logic [0:DD_W-1] dd_t;
endpackage

// File: rtl/dd_capture_mem.sv
// DEPTH x dd_t storage: one synchronous write port and one asynchronous read port.
// This module is the only driver of the storage array.
module dd_capture_mem
   import dd_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  dd_t           wr_data,
   input  logic [AW-1:0] rd_addr,
   output dd_t           rd_data
);
   dd_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   assign rd_data = r_mem[rd_addr];
endmodule

// File: rtl/dd_capture_fifo.sv
// Capture FIFO for the dd result stream: drops and flags writes when full.
// Optional saturating drop counter enabled by DD_CAPTURE_DROPCNT_EN.
module dd_capture_fifo
   import dd_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [0:7]    in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [0:7]    out_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          overflow
`ifdef DD_CAPTURE_DROPCNT_EN
   ,
   output logic [7:0]    drop_cnt
`endif
);
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   dd_t           w_rd_data;

   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && out_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign w_push  = in_valid && (!w_full || w_pop);
   assign w_drop  = in_valid && w_full && !w_pop;

   dd_capture_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk     (clk),
      .wr_en   (w_push),
      .wr_addr (r_wr_ptr),
      .wr_data (in_data),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

`ifdef DD_CAPTURE_DROPCNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (rst)                              r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 1'b1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign out_valid = !w_empty;
   assign out_data  = w_rd_data;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_overflow;
endmodule
